uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning bus cycles mem_valid may stay high without mem_ready before abort (>=2).
REQ-002 SHALL have parameter BYTE_TIMEOUT, default 65535, meaning maximum idle cycles between bytes of one packet (>=2).
REQ-003 SHALL have: clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have: resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have: rx_valid  in  1 / rx_data  in  8 / rx_ready  out  1  host command byte stream; byte accepted when rx_valid && rx_ready.
REQ-006 SHALL have: tx_valid  out  1 / tx_data  out  8 / tx_ready  in  1  response byte stream; byte taken when tx_valid && tx_ready.
REQ-007 SHALL have: mem_valid  out  1 / mem_instr  out  1 / mem_addr  out  32 / mem_wdata  out  32 / mem_wstrb  out  4  native memory bus initiator outputs.
REQ-008 SHALL have: mem_ready  in  1 / mem_rdata  in  32  native memory bus responder inputs.
REQ-009 SHALL have: busy  out  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement states IDLE, ADDR, DATA, BUS, RESP.
REQ-011 IDLE: byte 0x57 ('W') -> ADDR as write; 0x52 ('R') -> ADDR as read; any other byte -> RESP with single response 0x3F.
REQ-012 ADDR SHALL collect 4 bytes LSB first into address; then write -> DATA, read -> BUS.
REQ-013 DATA SHALL collect 4 bytes LSB first into wdata, then -> BUS.
REQ-014 rx_ready SHALL be 1 in IDLE/ADDR/DATA, 0 in BUS/RESP (back-pressure, no byte dropped).
REQ-015 Inter-byte counter SHALL clear on each accepted byte and on entering ADDR; reaching BYTE_TIMEOUT in ADDR/DATA -> IDLE, no bus cycle, no response.
REQ-016 BUS: mem_valid=1 from first BUS cycle; mem_addr={addr[31:2],2'b00}; mem_wdata=wdata; mem_wstrb=4'hF for write, 4'h0 for read; mem_instr=0 always; all stable while mem_valid=1.
REQ-017 Transfer completes in the cycle mem_valid && mem_ready; mem_valid SHALL be 0 the following cycle; read latches mem_rdata in that cycle.
REQ-018 Bus timeout counter SHALL count cycles with mem_valid=1; after TIMEOUT_CYCLES cycles without mem_ready, mem_valid drops next cycle, response 0x54 ('T').
REQ-019 mem_ready in the terminal timeout cycle SHALL count as success (ready wins).
REQ-020 Responses: write success -> 0x4B ('K'); read success -> 4 bytes of rdata LSB first; timeout -> 0x54 only.
REQ-021 RESP: tx_valid=1 with tx_data stable until tx_ready; next byte presented the cycle after acceptance (no gap required, none forbidden beyond one); after last byte -> IDLE.
REQ-022 mem_ready while mem_valid=0 SHALL be ignored.
REQ-023 rx byte arriving in same cycle as inter-byte timeout SHALL be accepted and timeout suppressed.

Reset
REQ-024 resetn=0 SHALL immediately force: state IDLE, mem_valid 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, mem_instr 0, tx_valid 0, tx_data 0, rx_ready 0, busy 0, all counters/byte indices 0.
REQ-025 rx_ready SHALL become 1 on first clk edge after resetn deasserts; reset mid-BUS or mid-RESP abandons the transaction with no further output.

Verification
REQ-026 Write: rx 57 10 00 00 10 EF BE AD DE, responder ready 3 cycles later -> mem_addr 0x10000010, mem_wdata 0xDEADBEEF, wstrb F, mem_valid high 4 cycles; tx 0x4B.
REQ-027 Read: rx 52 07 00 00 00, mem_rdata 0x12345678 on ready -> mem_addr 0x00000004, wstrb 0; tx 78 56 34 12 in order.
REQ-028 Timeout: TIMEOUT_CYCLES=16, read, mem_ready never high -> mem_valid high exactly 16 cycles; tx 0x54 only; busy 0 after.
REQ-029 Bad command: rx 0x41 -> tx 0x3F, mem_valid never asserted; following read packet completes normally.
REQ-030 Byte timeout: BYTE_TIMEOUT=32, rx 57 0x10 then 40 idle cycles -> IDLE, no mem_valid, no tx; then rx 52 00 00 00 00 reads address 0.
REQ-031 Back-pressure/reset: tx_ready low 10 cycles during read response -> tx_data 0x78 stable throughout; resetn pulsed low during BUS -> mem_valid and busy 0 asynchronously, no tx afterwards.

Source files
------------

// File: rtl/uart_bus_master.sv
// uart_bus_master: turns a byte-stream command protocol into single-beat
// native memory bus transfers.
//   'W' a0 a1 a2 a3 d0 d1 d2 d3 -> write, response 'K'
//   'R' a0 a1 a2 a3             -> read,  response rdata LSB first
//   bus timeout -> 'T', unknown command -> '?'
// Address and data bytes arrive LSB first; a stalled packet is dropped
// silently after BYTE_TIMEOUT idle cycles.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned BYTE_TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] BUS_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_TMO   = 8'h54;
  localparam logic [7:0] RSP_BAD   = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_e;

  state_e        state_q;
  logic          is_write_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] byte_cnt_q;
  logic [TW-1:0] bus_cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   resp_q;
  logic [1:0]    resp_left_q;
  logic          rx_ready_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic          mem_valid_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_wstrb_q;

  logic          rx_fire;
  logic          tx_fire;
  logic [31:0]   addr_d;
  logic [31:0]   wdata_d;

  // Handshakes and the shift-in values including the byte accepted this cycle.
  always_comb begin
    rx_fire = rx_valid && rx_ready_q;
    tx_fire = tx_valid_q && tx_ready;
    addr_d  = {rx_data, addr_q[31:8]};
    wdata_d = {rx_data, wdata_q[31:8]};
  end

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign mem_valid = mem_valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = (state_q != S_IDLE);

  // Protocol FSM with all interface outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      bus_cnt_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          idx_q      <= '0;
          byte_cnt_q <= '0;
          if (rx_fire) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              is_write_q <= (rx_data == CMD_WRITE);
              state_q    <= S_ADDR;
            end else begin
              rx_ready_q  <= 1'b0;
              tx_valid_q  <= 1'b1;
              tx_data_q   <= RSP_BAD;
              resp_left_q <= '0;
              state_q     <= S_RESP;
            end
          end
        end

        S_ADDR, S_DATA: begin
          // An arriving byte takes priority over an expiring idle counter.
          if (rx_fire) begin
            byte_cnt_q <= '0;
            idx_q      <= idx_q + 2'd1;
            if (state_q == S_ADDR) begin
              addr_q <= addr_d;
            end else begin
              wdata_q <= wdata_d;
            end
            if (idx_q == 2'd3) begin
              if (state_q == S_ADDR && is_write_q) begin
                state_q <= S_DATA;
              end else begin
                rx_ready_q  <= 1'b0;
                mem_valid_q <= 1'b1;
                mem_addr_q  <= (state_q == S_ADDR) ? {addr_d[31:2], 2'b00}
                                                   : {addr_q[31:2], 2'b00};
                mem_wdata_q <= (state_q == S_ADDR) ? wdata_q : wdata_d;
                mem_wstrb_q <= is_write_q ? 4'hF : 4'h0;
                bus_cnt_q   <= '0;
                state_q     <= S_BUS;
              end
            end
          end else if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_q <= '0;
            idx_q      <= '0;
            state_q    <= S_IDLE;
          end else begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
          end
        end

        S_BUS: begin
          // Ready is checked first so it wins over the final timeout cycle.
          if (mem_valid_q && mem_ready) begin
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= '0;
            tx_valid_q  <= 1'b1;
            state_q     <= S_RESP;
            if (is_write_q) begin
              tx_data_q   <= RSP_OK;
              resp_left_q <= '0;
            end else begin
              tx_data_q   <= mem_rdata[7:0];
              resp_q      <= mem_rdata;
              resp_left_q <= 2'd3;
            end
          end else if (bus_cnt_q == BUS_LAST) begin
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= '0;
            tx_valid_q  <= 1'b1;
            tx_data_q   <= RSP_TMO;
            resp_left_q <= '0;
            state_q     <= S_RESP;
          end else begin
            bus_cnt_q <= bus_cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          if (tx_fire) begin
            if (resp_left_q == 2'd0) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              resp_left_q <= resp_left_q - 2'd1;
              resp_q      <= resp_q >> 8;
              tx_data_q   <= resp_q[15:8];
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master (TIMEOUT_CYCLES=16, BYTE_TIMEOUT=32).
module tb_uart_bus_master;

  localparam int TO = 16;
  localparam int BT = 32;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(TO), .BYTE_TIMEOUT(BT)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Bus/tx observers, sampled mid-cycle.
  int          valid_cycles = 0;
  int          bus_unstable = 0;
  int          tx_unstable  = 0;
  int          tx_n         = 0;
  logic [7:0]  tx_log [0:255];
  logic [31:0] seen_addr  = '0;
  logic [31:0] seen_wdata = '0;
  logic [3:0]  seen_wstrb = '0;
  logic        seen_instr = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_txv   = 1'b0;
  logic        prev_txr   = 1'b0;
  logic [7:0]  prev_txd   = '0;

  always @(negedge clk) begin
    if (mem_valid === 1'b1) begin
      if (prev_valid && (mem_addr !== seen_addr || mem_wdata !== seen_wdata ||
                         mem_wstrb !== seen_wstrb))
        bus_unstable++;
      valid_cycles++;
      seen_addr  = mem_addr;
      seen_wdata = mem_wdata;
      seen_wstrb = mem_wstrb;
      seen_instr = mem_instr;
    end
    prev_valid = (mem_valid === 1'b1);
    if (tx_valid === 1'b1 && prev_txv && !prev_txr && tx_data !== prev_txd)
      tx_unstable++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      tx_log[tx_n] = tx_data;
      tx_n++;
    end
    prev_txv = (tx_valid === 1'b1);
    prev_txr = (tx_ready === 1'b1);
    prev_txd = tx_data;
  end

  // Responder: asserts mem_ready ready_delay cycles after mem_valid rises (-1 = never).
  int ready_delay = 3;
  int vcnt = 0;
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_valid === 1'b1) begin
        vcnt++;
        mem_ready = (ready_delay >= 0 && vcnt == ready_delay + 1);
      end else begin
        vcnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 100) begin cycle(1); n++; end
    if (n >= 100) begin
      n_vec++; n_err++;
      $display("FAIL send_byte: rx_ready stuck low, byte %h not accepted", b);
    end
    cycle(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [71:0] seq, input int n);
    for (int i = 0; i < n; i++) send_byte(seq[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || tx_valid !== 1'b0) && n < 300) begin cycle(1); n++; end
    n_vec++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b tx_valid=%b after 300 cycles, required 0/0", busy, tx_valid);
    end
  endtask

  task automatic test_reset();
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; mem_rdata = '0;
    resetn = 1'b0;
    cycle(3);
    n_vec++;
    if ({mem_valid, mem_wstrb, mem_addr, mem_wdata, mem_instr, tx_valid, tx_data, rx_ready, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b wstrb=%h addr=%h wdata=%h instr=%b txv=%b txd=%h rxr=%b busy=%b, required all 0",
               mem_valid, mem_wstrb, mem_addr, mem_wdata, mem_instr, tx_valid, tx_data, rx_ready, busy);
    end
    resetn = 1'b1;
    n_vec++;
    if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_release_rx_ready: got %b required 0", rx_ready); end
    cycle(1);
    n_vec++;
    if (rx_ready !== 1'b1) begin n_err++; $display("FAIL first_edge_rx_ready: got %b required 1", rx_ready); end
  endtask

  task automatic test_write();
    int v0 = valid_cycles;
    int t0 = tx_n;
    ready_delay = 3;
    send_seq(72'h57_10_00_00_10_EF_BE_AD_DE, 9);
    wait_idle();
    n_vec++;
    if (valid_cycles - v0 != 4) begin n_err++; $display("FAIL write_valid_cycles: got %0d required 4", valid_cycles - v0); end
    n_vec++;
    if (seen_addr !== 32'h1000_0010) begin n_err++; $display("FAIL write_addr: got %h required 10000010", seen_addr); end
    n_vec++;
    if (seen_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL write_wdata: got %h required deadbeef", seen_wdata); end
    n_vec++;
    if (seen_wstrb !== 4'hF || seen_instr !== 1'b0) begin
      n_err++; $display("FAIL write_wstrb_instr: got %h/%b required f/0", seen_wstrb, seen_instr);
    end
    n_vec++;
    if (tx_n - t0 != 1 || tx_log[t0] !== 8'h4B) begin
      n_err++; $display("FAIL write_resp: got %0d bytes first %h required 1 byte 4b", tx_n - t0, tx_log[t0]);
    end
    n_vec++;
    if (bus_unstable != 0) begin n_err++; $display("FAIL write_bus_stable: %0d changes while valid, required 0", bus_unstable); end
  endtask

  task automatic read_and_check(input string name, input logic [39:0] pkt, input logic [31:0] rd,
                                input logic [31:0] exp_addr, input int dly);
    int v0 = valid_cycles;
    int t0 = tx_n;
    ready_delay = dly;
    mem_rdata = rd;
    send_seq({32'h0, pkt}, 5);
    wait_idle();
    n_vec++;
    if (valid_cycles - v0 != dly + 1) begin
      n_err++; $display("FAIL %s_valid_cycles: got %0d required %0d", name, valid_cycles - v0, dly + 1);
    end
    n_vec++;
    if (seen_addr !== exp_addr || seen_wstrb !== 4'h0) begin
      n_err++; $display("FAIL %s_addr_wstrb: got %h/%h required %h/0", name, seen_addr, seen_wstrb, exp_addr);
    end
    n_vec++;
    if (tx_n - t0 != 4) begin n_err++; $display("FAIL %s_resp_len: got %0d required 4", name, tx_n - t0); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (tx_log[t0+i] !== rd[8*i +: 8]) begin
        n_err++; $display("FAIL %s_resp_byte%0d: got %h required %h", name, i, tx_log[t0+i], rd[8*i +: 8]);
      end
    end
  endtask

  task automatic test_read();
    read_and_check("read", 40'h52_07_00_00_00, 32'h1234_5678, 32'h0000_0004, 1);
  endtask

  task automatic test_timeout();
    int v0 = valid_cycles;
    int t0 = tx_n;
    ready_delay = -1;
    send_seq({32'h0, 40'h52_40_00_00_00}, 5);
    wait_idle();
    n_vec++;
    if (valid_cycles - v0 != TO) begin n_err++; $display("FAIL timeout_valid_cycles: got %0d required %0d", valid_cycles - v0, TO); end
    n_vec++;
    if (tx_n - t0 != 1 || tx_log[t0] !== 8'h54) begin
      n_err++; $display("FAIL timeout_resp: got %0d bytes first %h required 1 byte 54", tx_n - t0, tx_log[t0]);
    end
    n_vec++;
    if (busy !== 1'b0 || mem_valid !== 1'b0) begin n_err++; $display("FAIL timeout_idle: busy=%b valid=%b required 0/0", busy, mem_valid); end
  endtask

  task automatic test_bad_cmd();
    int v0 = valid_cycles;
    int t0 = tx_n;
    send_byte(8'h41);
    wait_idle();
    n_vec++;
    if (tx_n - t0 != 1 || tx_log[t0] !== 8'h3F) begin
      n_err++; $display("FAIL bad_cmd_resp: got %0d bytes first %h required 1 byte 3f", tx_n - t0, tx_log[t0]);
    end
    n_vec++;
    if (valid_cycles != v0) begin n_err++; $display("FAIL bad_cmd_no_bus: got %0d valid cycles required 0", valid_cycles - v0); end
    read_and_check("after_bad", 40'h52_20_00_00_00, 32'hCAFE_F00D, 32'h0000_0020, 2);
  endtask

  task automatic test_byte_timeout();
    int v0;
    int t0;
    // A byte landing on the expiring idle cycle is still taken.
    ready_delay = 1;
    mem_rdata = 32'h0A0B_0C0D;
    t0 = tx_n;
    send_byte(8'h52);
    cycle(BT - 1);
    send_byte(8'h00);
    cycle(BT - 1);
    send_seq({48'h0, 24'h00_00_00}, 3);
    wait_idle();
    n_vec++;
    if (tx_n - t0 != 4 || tx_log[t0] !== 8'h0D || tx_log[t0+3] !== 8'h0A) begin
      n_err++; $display("FAIL byte_timeout_edge: got %0d bytes first %h last %h required 4 bytes 0d..0a",
                        tx_n - t0, tx_log[t0], tx_log[t0+3]);
    end
    // Full timeout: packet abandoned silently.
    v0 = valid_cycles;
    t0 = tx_n;
    send_byte(8'h57);
    send_byte(8'h10);
    cycle(BT - 1);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL byte_timeout_early: busy=%b after %0d idle, required 1", busy, BT - 1); end
    cycle(1);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL byte_timeout_expire: busy=%b after %0d idle, required 0", busy, BT); end
    cycle(40 - BT);
    n_vec++;
    if (valid_cycles != v0 || tx_n != t0) begin
      n_err++; $display("FAIL byte_timeout_silent: valid cycles %0d tx bytes %0d required 0/0", valid_cycles - v0, tx_n - t0);
    end
    read_and_check("after_byte_timeout", 40'h52_00_00_00_00, 32'h0102_0304, 32'h0000_0000, 0);
  endtask

  task automatic test_backpressure();
    int n = 0;
    int t0 = tx_n;
    logic [31:0] rd = 32'h1234_5678;
    ready_delay = 0;
    mem_rdata = rd;
    tx_ready = 1'b0;
    send_seq({32'h0, 40'h52_00_00_00_00}, 5);
    while (tx_valid !== 1'b1 && n < 50) begin cycle(1); n++; end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h78) begin
        n_err++; $display("FAIL bp_hold_cycle%0d: tx_valid=%b tx_data=%h required 1/78", i, tx_valid, tx_data);
      end
      cycle(1);
    end
    tx_ready = 1'b1;
    wait_idle();
    n_vec++;
    if (tx_unstable != 0) begin n_err++; $display("FAIL bp_stable: %0d tx_data changes while stalled, required 0", tx_unstable); end
    n_vec++;
    if (tx_n - t0 != 4 || tx_log[t0] !== 8'h78 || tx_log[t0+1] !== 8'h56 ||
        tx_log[t0+2] !== 8'h34 || tx_log[t0+3] !== 8'h12) begin
      n_err++; $display("FAIL bp_resp: got %0d bytes %h %h %h %h required 78 56 34 12",
                        tx_n - t0, tx_log[t0], tx_log[t0+1], tx_log[t0+2], tx_log[t0+3]);
    end
  endtask

  task automatic test_reset_mid_bus();
    int n = 0;
    int t0;
    ready_delay = -1;
    send_seq({32'h0, 40'h52_00_00_00_00}, 5);
    while (mem_valid !== 1'b1 && n < 20) begin cycle(1); n++; end
    cycle(3);
    t0 = tx_n;
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_bus_async: valid=%b busy=%b txv=%b rxr=%b required 0/0/0/0",
                        mem_valid, busy, tx_valid, rx_ready);
    end
    cycle(2);
    resetn = 1'b1;
    cycle(20);
    n_vec++;
    if (tx_n != t0 || mem_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_bus_after: tx bytes %0d valid=%b busy=%b rxr=%b required 0/0/0/1",
                        tx_n - t0, mem_valid, busy, rx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_bad_cmd();
    test_byte_timeout();
    test_backpressure();
    test_reset_mid_bus();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
